// File: rtl/acq_pkg.sv
// Shared types and helpers for the acquisition peak search.
package acq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } peak_state_t;

   // Power width for a signed I/Q width: holds 2*(-2^(in_w-1))^2 without overflow.
   function automatic int unsigned pow_w(input int unsigned in_w);
      return 2 * in_w;
   endfunction

endpackage

// File: rtl/iq_power.sv
// Two-stage pipelined I^2+Q^2 with a sideband tag and a clear that drops pipe contents.
module iq_power
   import acq_pkg::*;
#(
   parameter int unsigned IN_W  = 11,
   parameter int unsigned TAG_W = 16,
   localparam int unsigned POW_W = pow_w(IN_W)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic signed [IN_W-1:0] I,
   input  logic signed [IN_W-1:0] Q,
   input  logic [TAG_W-1:0]       tag,
   output logic                   s1_valid,
   output logic                   out_valid,
   output logic [POW_W-1:0]       pow,
   output logic [TAG_W-1:0]       out_tag
);

   logic signed [POW_W-1:0] i_ext;
   logic signed [POW_W-1:0] q_ext;
   logic signed [POW_W-1:0] i_sq;
   logic signed [POW_W-1:0] q_sq;
   logic [POW_W-1:0]        sq_i;
   logic [POW_W-1:0]        sq_q;
   logic [TAG_W-1:0]        tag1;

   assign i_ext = POW_W'(I);
   assign q_ext = POW_W'(Q);
   assign i_sq  = i_ext * i_ext;
   assign q_sq  = q_ext * q_ext;

   // Stage 1: register the two squares (always non-negative) and the sample tag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         sq_i     <= '0;
         sq_q     <= '0;
         tag1     <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            sq_i <= $unsigned(i_sq);
            sq_q <= $unsigned(q_sq);
            tag1 <= tag;
         end
      end
   end

   // Stage 2: unsigned sum; clear drops whatever stage 1 held.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         pow       <= '0;
         out_tag   <= '0;
      end else begin
         out_valid <= s1_valid & ~clear;
         if (s1_valid) begin
            pow     <= sq_i + sq_q;
            out_tag <= tag1;
         end
      end
   end

endmodule

// File: rtl/acq_peak_search.sv
// Peak / second-peak search over one armed window of correlator I/Q sums.
module acq_peak_search
   import acq_pkg::*;
#(
   parameter int unsigned IN_W  = 11,
   parameter int unsigned IDX_W = 16,
   localparam int unsigned POW_W = pow_w(IN_W)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [IDX_W-1:0]       search_len,
   input  logic [POW_W-1:0]       threshold,
   input  logic                   in_valid,
   input  logic signed [IN_W-1:0] I,
   input  logic signed [IN_W-1:0] Q,
   output logic                   busy,
   output logic                   res_valid,
   output logic [POW_W-1:0]       peak_pow,
   output logic [IDX_W-1:0]       peak_idx,
   output logic [POW_W-1:0]       second_pow,
   output logic                   found
);

   peak_state_t      state;
   peak_state_t      state_nx;
   logic             accept;
   logic             clear;
   logic [IDX_W-1:0] len_eff;
   logic [IDX_W-1:0] len_reg;
   logic [POW_W-1:0] thr_reg;
   logic [IDX_W-1:0] in_cnt;
   logic [IDX_W-1:0] pipe_tag;

   logic             s1_valid;
   logic             p_valid;
   logic [POW_W-1:0] p_pow;
   logic [IDX_W-1:0] p_idx;

   logic [POW_W-1:0] peak_trk;
   logic [POW_W-1:0] second_trk;
   logic [IDX_W-1:0] idx_trk;
   logic [POW_W-1:0] peak_nx;
   logic [POW_W-1:0] second_nx;
   logic [IDX_W-1:0] idx_nx;

   assign len_eff  = (search_len == '0) ? IDX_W'(1) : search_len;
   // A sample arriving with start is index 0 of the new window.
   assign pipe_tag = start ? '0 : in_cnt;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next state, sample acceptance and pipe clear; start restarts from any state.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      clear    = 1'b0;
      if (start) begin
         clear    = 1'b1;
         accept   = in_valid;
         state_nx = (in_valid && len_eff == IDX_W'(1)) ? FLUSH : SEARCH;
      end else begin
         case (state)
            IDLE:   state_nx = IDLE;
            SEARCH: begin
               if (in_valid) begin
                  accept = 1'b1;
                  if (in_cnt + IDX_W'(1) == len_reg) state_nx = FLUSH;
               end
            end
            // Last sample sits in stage 2 once stage 1 is empty; it lands with the DONE edge.
            FLUSH:   if (!s1_valid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Window parameters and accepted-sample counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         len_reg <= '0;
         thr_reg <= '0;
         in_cnt  <= '0;
      end else if (start) begin
         len_reg <= len_eff;
         thr_reg <= threshold;
         in_cnt  <= in_valid ? IDX_W'(1) : '0;
      end else if (accept) begin
         in_cnt  <= in_cnt + IDX_W'(1);
      end
   end

   iq_power #(
      .IN_W  (IN_W),
      .TAG_W (IDX_W)
   ) u_iq_power (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (clear),
      .in_valid  (accept),
      .I         (I),
      .Q         (Q),
      .tag       (pipe_tag),
      .s1_valid  (s1_valid),
      .out_valid (p_valid),
      .pow       (p_pow),
      .out_tag   (p_idx)
   );

   // Tracker update; strict compares so the first occurrence of a tie keeps the peak.
   always_comb begin
      peak_nx   = peak_trk;
      second_nx = second_trk;
      idx_nx    = idx_trk;
      if (p_valid) begin
         if (p_pow > peak_trk) begin
            second_nx = peak_trk;
            peak_nx   = p_pow;
            idx_nx    = p_idx;
         end else if (p_pow > second_trk) begin
            second_nx = p_pow;
         end
      end
   end

   // Tracker registers, cleared whenever a window is armed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         peak_trk   <= '0;
         second_trk <= '0;
         idx_trk    <= '0;
      end else if (clear) begin
         peak_trk   <= '0;
         second_trk <= '0;
         idx_trk    <= '0;
      end else begin
         peak_trk   <= peak_nx;
         second_trk <= second_nx;
         idx_trk    <= idx_nx;
      end
   end

   // Result registers: loaded on entry to DONE, held until the next DONE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy       <= 1'b0;
         res_valid  <= 1'b0;
         peak_pow   <= '0;
         peak_idx   <= '0;
         second_pow <= '0;
         found      <= 1'b0;
      end else begin
         busy      <= (state_nx == SEARCH) || (state_nx == FLUSH);
         res_valid <= (state_nx == DONE);
         if (state_nx == DONE) begin
            peak_pow   <= peak_nx;
            peak_idx   <= idx_nx;
            second_pow <= second_nx;
            found      <= (peak_nx > thr_reg);
         end
      end
   end

endmodule

// File: tb/tb_acq_peak_search.sv
// Self-checking bench for acq_peak_search: directed table, corner sequences, random windows.
module tb_acq_peak_search;

   logic               clk = 1'b0;
   logic               resetn;
   logic               start;
   logic [15:0]        search_len;
   logic [21:0]        threshold;
   logic               in_valid;
   logic signed [10:0] I;
   logic signed [10:0] Q;
   logic               busy;
   logic               res_valid;
   logic [21:0]        peak_pow;
   logic [15:0]        peak_idx;
   logic [21:0]        second_pow;
   logic               found;

   always #5 clk = ~clk;

   acq_peak_search #(
      .IN_W  (11),
      .IDX_W (16)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .search_len (search_len),
      .threshold  (threshold),
      .in_valid   (in_valid),
      .I          (I),
      .Q          (Q),
      .busy       (busy),
      .res_valid  (res_valid),
      .peak_pow   (peak_pow),
      .peak_idx   (peak_idx),
      .second_pow (second_pow),
      .found      (found)
   );

   typedef struct packed {
      logic [21:0] peak;
      logic [15:0] idx;
      logic [21:0] second;
      logic        found;
   } res_t;

   typedef struct packed {
      logic [15:0] len;
      logic [21:0] thr;
      logic [3:0]  n;
      res_t        exp;
   } vec_t;

   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   si_a[16];
   int   sq_a[16];
   vec_t tbl[8];
   int   tv_i[8][8];
   int   tv_q[8][8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: first max(len,1) samples, strict compares, first occurrence wins.
   function automatic res_t model(input int len, input logic [21:0] thr);
      res_t   r;
      longint p;
      int     l;
      l = (len == 0) ? 1 : len;
      r = '0;
      for (int j = 0; j < l; j++) begin
         p = longint'(si_a[j]) * si_a[j] + longint'(sq_a[j]) * sq_a[j];
         if (p > longint'(r.peak)) begin
            r.second = r.peak;
            r.peak   = 22'(p);
            r.idx    = 16'(j);
         end else if (p > longint'(r.second)) begin
            r.second = 22'(p);
         end
      end
      r.found = (r.peak > thr);
      return r;
   endfunction

   // Scoreboard: every res_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin : mon
      res_t e;
      if (resetn === 1'b1 && res_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_res_valid actual=1 required=0");
         end else begin
            e = exp_q.pop_front();
            chk("peak_pow", 64'(peak_pow), 64'(e.peak));
            chk("peak_idx", 64'(peak_idx), 64'(e.idx));
            chk("second_pow", 64'(second_pow), 64'(e.second));
            chk("found", 64'(found), 64'(e.found));
            chk("busy_at_res", 64'(busy), 64'd0);
         end
      end
   end

   // Arm a window, then drive n samples from si_a/sq_a with random idle gaps.
   task automatic drive_window(input int len, input logic [21:0] thr, input int n,
                               input bit with_sample, input int gapmax);
      int j = 0;
      @(posedge clk); #1;
      start      = 1'b1;
      search_len = 16'(len);
      threshold  = thr;
      if (with_sample) begin
         in_valid = 1'b1;
         I        = 11'(si_a[0]);
         Q        = 11'(sq_a[0]);
         j        = 1;
      end else begin
         in_valid = 1'b0;
      end
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      while (j < n) begin
         repeat ($urandom_range(gapmax, 0)) begin
            in_valid = 1'b0;
            I        = 11'($urandom);
            Q        = 11'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         I        = 11'(si_a[j]);
         Q        = 11'(sq_a[j]);
         @(posedge clk); #1;
         j++;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout actual=%0d required=0 results pending", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      int   len;
      logic [21:0] thr;

      tbl[0] = '{len:16'd4, thr:22'd50,      n:4'd4, exp:'{peak:22'd100,     idx:16'd1, second:22'd100,     found:1'b1}};
      tbl[1] = '{len:16'd3, thr:22'd0,       n:4'd3, exp:'{peak:22'd0,       idx:16'd0, second:22'd0,       found:1'b0}};
      tbl[2] = '{len:16'd2, thr:22'd2097151, n:4'd2, exp:'{peak:22'd2097152, idx:16'd0, second:22'd2095105, found:1'b1}};
      tbl[3] = '{len:16'd3, thr:22'd2097152, n:4'd3, exp:'{peak:22'd2097152, idx:16'd0, second:22'd50,      found:1'b0}};
      tbl[4] = '{len:16'd0, thr:22'd7,       n:4'd3, exp:'{peak:22'd8,       idx:16'd0, second:22'd0,       found:1'b1}};
      tbl[5] = '{len:16'd5, thr:22'd25,      n:4'd5, exp:'{peak:22'd25,      idx:16'd4, second:22'd16,      found:1'b0}};
      tbl[6] = '{len:16'd5, thr:22'd24,      n:4'd7, exp:'{peak:22'd25,      idx:16'd0, second:22'd16,      found:1'b1}};
      tbl[7] = '{len:16'd3, thr:22'd0,       n:4'd3, exp:'{peak:22'd16,      idx:16'd2, second:22'd9,       found:1'b1}};
      tv_i[0] = '{3, 10, -6, 1, 0, 0, 0, 0};          tv_q[0] = '{4, 0, 8, 1, 0, 0, 0, 0};
      tv_i[1] = '{0, 0, 0, 0, 0, 0, 0, 0};            tv_q[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
      tv_i[2] = '{-1024, 1023, 0, 0, 0, 0, 0, 0};     tv_q[2] = '{-1024, -1024, 0, 0, 0, 0, 0, 0};
      tv_i[3] = '{-1024, 0, 5, 0, 0, 0, 0, 0};        tv_q[3] = '{-1024, 0, 5, 0, 0, 0, 0, 0};
      tv_i[4] = '{2, 9, 9, 0, 0, 0, 0, 0};            tv_q[4] = '{2, 9, 9, 0, 0, 0, 0, 0};
      tv_i[5] = '{1, 2, 3, 4, 5, 0, 0, 0};            tv_q[5] = '{0, 0, 0, 0, 0, 0, 0, 0};
      tv_i[6] = '{5, 4, 0, -2, 1, 30, 30, 0};         tv_q[6] = '{0, 0, 3, 0, 0, 30, 30, 0};
      tv_i[7] = '{0, 3, 0, 0, 0, 0, 0, 0};            tv_q[7] = '{3, 0, -4, 0, 0, 0, 0, 0};

      resetn     = 1'b0;
      start      = 1'b0;
      in_valid   = 1'b0;
      search_len = '0;
      threshold  = '0;
      I          = '0;
      Q          = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_peak_pow", 64'(peak_pow), 64'd0);
      chk("rst_peak_idx", 64'(peak_idx), 64'd0);
      chk("rst_second_pow", 64'(second_pow), 64'd0);
      chk("rst_found", 64'(found), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;

      // Result latency: res_valid exactly on the third negedge after the last accepted sample.
      for (int j = 0; j < 16; j++) begin si_a[j] = 0; sq_a[j] = 0; end
      exp_q.push_back('{peak:22'd0, idx:16'd0, second:22'd0, found:1'b0});
      drive_window(3, 22'd0, 3, 1'b0, 0);
      @(negedge clk);
      chk("lat_k0_res_valid", 64'(res_valid), 64'd0);
      chk("lat_k0_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("lat_k1_res_valid", 64'(res_valid), 64'd0);
      @(negedge clk);
      chk("lat_k2_res_valid", 64'(res_valid), 64'd1);
      @(negedge clk);
      chk("lat_k3_res_valid", 64'(res_valid), 64'd0);
      wait_drain("latency");

      // Directed table.
      for (int t = 0; t < 8; t++) begin
         for (int j = 0; j < 8; j++) begin
            si_a[j] = tv_i[t][j];
            sq_a[j] = tv_q[t][j];
         end
         exp_q.push_back(tbl[t].exp);
         drive_window(int'(tbl[t].len), tbl[t].thr, int'(tbl[t].n), t[0], t % 3);
         wait_drain("table");
      end

      // Reset in the middle of a search: outputs cleared, no result afterwards.
      for (int j = 0; j < 8; j++) begin si_a[j] = 20 + j; sq_a[j] = 7; end
      drive_window(8, 22'd0, 3, 1'b1, 0);
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_res_valid", 64'(res_valid), 64'd0);
      chk("midrst_peak_pow", 64'(peak_pow), 64'd0);
      chk("midrst_peak_idx", 64'(peak_idx), 64'd0);
      chk("midrst_second_pow", 64'(second_pow), 64'd0);
      chk("midrst_found", 64'(found), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("postrst_busy", 64'(busy), 64'd0);
      chk("postrst_peak_pow", 64'(peak_pow), 64'd0);

      // Abort after 2 of 8 samples; restart carries its own index-0 sample.
      si_a[0] = 30; sq_a[0] = 30; si_a[1] = 30; sq_a[1] = 30;
      drive_window(8, 22'd0, 2, 1'b0, 0);
      si_a[0] = 1; sq_a[0] = 2; si_a[1] = 2; sq_a[1] = 1; si_a[2] = 0; sq_a[2] = 1;
      exp_q.push_back('{peak:22'd5, idx:16'd0, second:22'd5, found:1'b1});
      drive_window(3, 22'd0, 3, 1'b1, 1);
      wait_drain("abort_search");

      // Abort during FLUSH: the old pipe contents must not reach the new window.
      si_a[0] = 100; sq_a[0] = 0; si_a[1] = 100; sq_a[1] = 0;
      drive_window(2, 22'd0, 2, 1'b0, 0);
      si_a[0] = 3; sq_a[0] = 0;
      exp_q.push_back('{peak:22'd9, idx:16'd0, second:22'd0, found:1'b1});
      drive_window(1, 22'd0, 1, 1'b1, 0);
      wait_drain("abort_flush");

      // Random windows checked against the reference model.
      for (int w = 0; w < 8; w++) begin
         len = int'($urandom_range(12, 1));
         thr = 22'($urandom_range(2097152, 0));
         if (w[0]) thr = 22'($urandom_range(20, 0));
         for (int j = 0; j < 16; j++) begin
            if (w[0]) begin
               si_a[j] = int'($urandom_range(6, 0)) - 3;
               sq_a[j] = int'($urandom_range(6, 0)) - 3;
            end else begin
               si_a[j] = int'($urandom_range(2047, 0)) - 1024;
               sq_a[j] = int'($urandom_range(2047, 0)) - 1024;
            end
         end
         r = model(len, thr);
         exp_q.push_back(r);
         drive_window(len, thr, len + int'($urandom_range(2, 0)), w[1], 2);
         wait_drain("random");
      end

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
